int_ctx_stack: RTL and testbench

INT_CTX_STACK -- requirements
Module: int_ctx_stack

---
 rtl/int_ctx_stack_if.sv | 33 +++
 rtl/int_ctx_stack.sv | 74 +++++++
 tb/tb_int_ctx_stack.sv | 102 ++++++++++
 3 files changed

// File: rtl/int_ctx_stack_if.sv
// Bus bundle for the interrupt context stack: control, save data, top-of-stack
// view and sticky error status.
interface int_ctx_stack_if #(
  parameter int PC_W   = 12,
  parameter int FLAG_W = 2,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              cen;
  logic              push;
  logic              pop;
  logic [PC_W-1:0]   pc_i;
  logic [FLAG_W-1:0] flags_i;
  logic              clr_err;
  logic [PC_W-1:0]   pc_o;
  logic [FLAG_W-1:0] flags_o;
  logic [CW-1:0]     count_o;
  logic              empty_o;
  logic              full_o;
  logic              ovf_o;
  logic              unf_o;

  modport master (
    output cen, push, pop, pc_i, flags_i, clr_err,
    input  pc_o, flags_o, count_o, empty_o, full_o, ovf_o, unf_o
  );

  modport slave (
    input  cen, push, pop, pc_i, flags_i, clr_err,
    output pc_o, flags_o, count_o, empty_o, full_o, ovf_o, unf_o
  );
endinterface

// File: rtl/int_ctx_stack.sv
// Nested interrupt context stack: saves {pc, flags} on entry, restores on return,
// with sticky overflow/underflow flags.
module int_ctx_stack #(
  parameter int PC_W   = 12,
  parameter int FLAG_W = 2,
  parameter int DEPTH  = 4
) (
  input logic             gClk,
  input logic             rst,
  int_ctx_stack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [FLAG_W-1:0] flags;
  } ctx_t;

  ctx_t          r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_unf;

  logic          w_empty, w_full;
  logic          w_replace, w_push_new, w_pop_top;
  logic          w_ovf_evt, w_unf_evt;
  logic [CW-1:0] w_cnt_m1;
  logic [IW-1:0] w_top, w_widx;
  ctx_t          w_wdata;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_cnt_m1 = r_count - CW'(1);
  assign w_top    = w_cnt_m1[IW-1:0];
  assign w_wdata  = '{pc: bus.pc_i, flags: bus.flags_i};

  // Push+pop on a non-empty stack is an in-place replace; on empty it degrades to a push.
  assign w_replace  = bus.push && bus.pop && !w_empty;
  assign w_push_new = bus.push && !w_replace && !w_full;
  assign w_ovf_evt  = bus.push && !bus.pop && w_full;
  assign w_pop_top  = bus.pop && !bus.push && !w_empty;
  assign w_unf_evt  = bus.pop && !bus.push && w_empty;
  assign w_widx     = w_replace ? w_top : r_count[IW-1:0];

  always_ff @(posedge gClk) begin
    if (bus.cen) begin
      if (rst) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
        r_unf   <= 1'b0;
      end else begin
        if (w_push_new)     r_count <= r_count + CW'(1);
        else if (w_pop_top) r_count <= w_cnt_m1;
        r_ovf <= w_ovf_evt | (r_ovf & ~bus.clr_err);
        r_unf <= w_unf_evt | (r_unf & ~bus.clr_err);
      end
    end
  end

  // Storage needs no reset; the count alone defines which slots are live.
  always_ff @(posedge gClk) begin
    if (bus.cen && !rst && (w_replace || w_push_new))
      r_mem[w_widx] <= w_wdata;
  end

  assign bus.pc_o    = w_empty ? '0 : r_mem[w_top].pc;
  assign bus.flags_o = w_empty ? '0 : r_mem[w_top].flags;
  assign bus.count_o = r_count;
  assign bus.empty_o = w_empty;
  assign bus.full_o  = w_full;
  assign bus.ovf_o   = r_ovf;
  assign bus.unf_o   = r_unf;
endmodule

// File: tb/tb_int_ctx_stack.sv
// Directed bench for int_ctx_stack with hand-computed expectations.
module tb_int_ctx_stack;
  logic gClk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 gClk = ~gClk;

  int_ctx_stack_if #(.PC_W(12), .FLAG_W(2), .DEPTH(4)) bus ();
  int_ctx_stack #(.PC_W(12), .FLAG_W(2), .DEPTH(4)) dut (.gClk(gClk), .rst(rst), .bus(bus));

  task automatic cyc(input logic c, input logic r, input logic pu, input logic po,
                     input logic [11:0] pc, input logic [1:0] fl, input logic clr);
    bus.cen = c; rst = r; bus.push = pu; bus.pop = po;
    bus.pc_i = pc; bus.flags_i = fl; bus.clr_err = clr;
    @(posedge gClk);
    #1;
    bus.cen = 1'b1; rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      $error("%s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic st(input string tag, input int pc, input int fl, input int cnt,
                    input int emp, input int ful, input int ovf, input int unf);
    chk({tag, ".pc"},    int'(bus.pc_o),    pc);
    chk({tag, ".flags"}, int'(bus.flags_o), fl);
    chk({tag, ".count"}, int'(bus.count_o), cnt);
    chk({tag, ".empty"}, int'(bus.empty_o), emp);
    chk({tag, ".full"},  int'(bus.full_o),  ful);
    chk({tag, ".ovf"},   int'(bus.ovf_o),   ovf);
    chk({tag, ".unf"},   int'(bus.unf_o),   unf);
  endtask

  initial begin
    bus.cen = 1'b1; rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
    bus.pc_i = '0; bus.flags_i = '0; bus.clr_err = 1'b0;

    cyc(1, 1, 0, 0, 12'h000, 2'b00, 0);
    st("reset", 0, 0, 0, 1, 0, 0, 0);

    // nested push/pop
    cyc(1, 0, 1, 0, 12'h100, 2'b01, 0); st("nest_p1", 'h100, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 12'h200, 2'b10, 0); st("nest_p2", 'h200, 2, 2, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 12'h300, 2'b11, 0); st("nest_p3", 'h300, 3, 3, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 12'h000, 2'b00, 0); st("nest_o1", 'h200, 2, 2, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 12'h000, 2'b00, 0); st("nest_o2", 'h100, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 12'h000, 2'b00, 0); st("nest_o3", 0, 0, 0, 1, 0, 0, 0);

    // overflow
    cyc(1, 0, 1, 0, 12'h011, 2'b01, 0);
    cyc(1, 0, 1, 0, 12'h022, 2'b10, 0);
    cyc(1, 0, 1, 0, 12'h033, 2'b11, 0);
    cyc(1, 0, 1, 0, 12'h044, 2'b00, 0); st("fill4", 'h044, 0, 4, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 12'hABC, 2'b11, 0); st("ovf", 'h044, 0, 4, 0, 1, 1, 0);
    cyc(1, 0, 1, 1, 12'h055, 2'b10, 0); st("repl_full", 'h055, 2, 4, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 12'h000, 2'b00, 1); st("clr_ovf", 'h055, 2, 4, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 12'hABC, 2'b11, 1); st("ovf_setwins", 'h055, 2, 4, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 12'h000, 2'b00, 1); st("clr_ovf2", 'h055, 2, 4, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 12'h000, 2'b00, 0); st("below_3", 'h033, 3, 3, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 12'h000, 2'b00, 0); st("below_2", 'h022, 2, 2, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 12'h000, 2'b00, 0); st("below_1", 'h011, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 12'h000, 2'b00, 0); st("below_0", 0, 0, 0, 1, 0, 0, 0);

    // underflow and push+pop on empty
    cyc(1, 0, 0, 1, 12'h000, 2'b00, 0); st("unf", 0, 0, 0, 1, 0, 0, 1);
    cyc(1, 0, 1, 1, 12'h777, 2'b01, 0); st("pp_empty", 'h777, 1, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 12'h000, 2'b00, 1); st("clr_unf", 'h777, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 12'h000, 2'b00, 0); st("unf_drain", 0, 0, 0, 1, 0, 0, 0);

    // replace top
    cyc(1, 0, 1, 0, 12'h100, 2'b01, 0);
    cyc(1, 0, 1, 0, 12'h200, 2'b10, 0); st("rep_pre", 'h200, 2, 2, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 12'h5A5, 2'b11, 0); st("rep", 'h5A5, 3, 2, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 12'h000, 2'b00, 0); st("rep_pop", 'h100, 1, 1, 0, 0, 0, 0);

    // clock gating, then reset priority
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 12'h321, 2'b10, 0);
      chk("gate_count", int'(bus.count_o), 1);
      chk("gate_pc", int'(bus.pc_o), 'h100);
    end
    cyc(0, 1, 0, 0, 12'h000, 2'b00, 0); st("gate_rst", 'h100, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 12'h222, 2'b10, 0);
    cyc(1, 0, 1, 0, 12'h333, 2'b11, 0); st("pre_rst", 'h333, 3, 3, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 12'h000, 2'b00, 0);
    cyc(1, 0, 1, 0, 12'h444, 2'b00, 0);
    cyc(1, 0, 1, 0, 12'h555, 2'b00, 0); st("ovf_pre_rst", 'h444, 0, 4, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 12'h000, 2'b00, 0); st("cnt3", 'h333, 3, 3, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 12'h666, 2'b01, 1); st("rst_push", 0, 0, 0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
